// File: rtl/seq_list_sequencer_pkg.sv
// Shared definitions for the sequence-list sequencer: FSM encoding and
// default sizing of the list, index and timeout counter.
package seq_pkg;

  localparam int          SEQ_LS      = 36;
  localparam int          SEQ_IW      = 6;
  localparam int          SEQ_TW      = 16;
  localparam logic [15:0] SEQ_TMO_MAX = 16'd50000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/seq_list_sequencer_lsb_pri_enc.sv
// Combinational lowest-set-bit encoder: idx is the position of the lowest
// set bit of vec, valid is high when any bit is set.
module lsb_pri_enc
  import seq_pkg::*;
#(
  parameter int W  = SEQ_LS,
  parameter int IW = SEQ_IW
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scanning downward lets the lowest set bit be the final assignment.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_list_sequencer.sv
// Per-frame sequence-list dispatcher: captures the enable vector and starts each
// enabled sequence in ascending order. Optional stats ports: SEQ_LIST_STATS_EN.
module seq_list_sequencer
  import seq_pkg::*;
#(
  parameter int             LS      = SEQ_LS,
  parameter int             IW      = SEQ_IW,
  parameter int             TW      = SEQ_TW,
  parameter logic [TW-1:0]  TMO_MAX = TW'(SEQ_TMO_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          sys_tmr_strb,
  input  logic [LS-1:0] seq_list_en,
  input  logic          seq_done_strb,
  input  logic          err_clr,
  output logic          seq_start_strb,
  output logic [IW-1:0] seq_index,
  output logic          seq_list_done_strb,
  output logic          busy,
  output logic          frame_overrun,
  output logic          seq_timeout
`ifdef SEQ_LIST_STATS_EN
  ,
  output logic [15:0]   last_list_cycles,
  output logic [IW-1:0] last_list_count
`endif
);

  localparam logic [TW-1:0] TMO_LAST = TMO_MAX - TW'(1);

  seq_state_t    state_reg, state_next;
  logic [LS-1:0] pending_reg;
  logic [TW-1:0] wait_cnt_reg;
  logic          strb_z1_reg, strb_z2_reg;
  logic          cap_z1_reg, cap_z2_reg;
  logic [IW-1:0] enc_idx;
  logic          enc_valid;
  logic          capture, dispatch, tmo_hit, cnt_inc, overrun_set;

  lsb_pri_enc #(.W(LS), .IW(IW)) u_enc (
    .vec   (pending_reg),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // A strobe is dropped if a list is running or another strobe is still in flight.
  assign overrun_set        = sys_tmr_strb & ((state_reg != ST_IDLE) | strb_z1_reg | strb_z2_reg);
  assign busy               = (state_reg != ST_IDLE);
  assign seq_list_done_strb = (state_reg == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    dispatch   = 1'b0;
    tmo_hit    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (strb_z2_reg && cap_z2_reg && enable) begin
          capture    = 1'b1;
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (enc_valid) begin
          dispatch   = 1'b1;
          state_next = ST_WAIT;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (seq_done_strb) begin
          state_next = ST_SCAN;
        end else if (wait_cnt_reg == TMO_LAST) begin
          tmo_hit    = 1'b1;
          state_next = ST_SCAN;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Two-stage delay so the capture sees the vector upstream updates after the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strb_z1_reg <= 1'b0;
      strb_z2_reg <= 1'b0;
      cap_z1_reg  <= 1'b0;
      cap_z2_reg  <= 1'b0;
    end else begin
      strb_z1_reg <= sys_tmr_strb;
      strb_z2_reg <= strb_z1_reg;
      cap_z1_reg  <= sys_tmr_strb & ~overrun_set;
      cap_z2_reg  <= cap_z1_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_reg    <= '0;
      seq_index      <= '0;
      seq_start_strb <= 1'b0;
      wait_cnt_reg   <= '0;
      frame_overrun  <= 1'b0;
      seq_timeout    <= 1'b0;
    end else begin
      seq_start_strb <= dispatch;
      if (capture)
        pending_reg <= seq_list_en;
      else if (dispatch)
        pending_reg <= pending_reg & (pending_reg - LS'(1));
      if (dispatch) begin
        seq_index    <= enc_idx;
        wait_cnt_reg <= '0;
      end else if (cnt_inc) begin
        wait_cnt_reg <= wait_cnt_reg + TW'(1);
      end
      // A new error event takes priority over a same-cycle clear.
      if (overrun_set)  frame_overrun <= 1'b1;
      else if (err_clr) frame_overrun <= 1'b0;
      if (tmo_hit)      seq_timeout   <= 1'b1;
      else if (err_clr) seq_timeout   <= 1'b0;
    end
  end

`ifdef SEQ_LIST_STATS_EN
  logic [15:0]   list_cyc_reg;
  logic [IW-1:0] list_cnt_reg;

  // list_cyc_reg starts at 1 on capture so DONE reports capture-to-DONE distance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      list_cyc_reg     <= '0;
      list_cnt_reg     <= '0;
      last_list_cycles <= '0;
      last_list_count  <= '0;
    end else begin
      if (capture)
        list_cyc_reg <= 16'd1;
      else if (busy && list_cyc_reg != 16'hFFFF)
        list_cyc_reg <= list_cyc_reg + 16'd1;
      if (capture)
        list_cnt_reg <= '0;
      else if (dispatch)
        list_cnt_reg <= list_cnt_reg + IW'(1);
      if (state_reg == ST_DONE) begin
        last_list_cycles <= list_cyc_reg;
        last_list_count  <= list_cnt_reg;
      end
    end
  end
`endif

endmodule
